// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: A is read-only, B reads and writes.
// Define MEM_ARB_RR_EN for strict alternation on contention; default is B priority with an A starvation limit.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic {
        WIN_A = 1'b0,
        WIN_B = 1'b1
    } win_e;

    localparam logic [7:0] STARVE_LIM = STARVE_LIMIT[7:0];

    win_e                  last_win_q, last_win_d;
    logic [7:0]            starve_cnt_q, starve_cnt_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
    logic                  pick_a;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_a = (last_win_q == WIN_B);
`else
        pick_a = (starve_cnt_q == STARVE_LIM);
`endif
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        mem_we   = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                a_gnt = pick_a;
                b_gnt = ~pick_a;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
            // With no grant the RAM keeps seeing the last issued address.
            if (a_gnt) begin
                mem_addr = a_addr;
            end else if (b_gnt) begin
                mem_addr = b_addr;
            end else begin
                mem_addr = addr_hold_q;
            end
            mem_data = b_wdata;
            mem_we   = b_gnt & b_we;
        end
    end

    always_comb begin
        addr_hold_d = mem_addr;
        a_rvalid_d  = a_gnt;
        b_rvalid_d  = b_gnt & ~b_we;
        last_win_d  = last_win_q;
        if (a_gnt) begin
            last_win_d = WIN_A;
        end else if (b_gnt) begin
            last_win_d = WIN_B;
        end
`ifdef MEM_ARB_RR_EN
        starve_cnt_d = '0;
`else
        if (a_gnt || !a_req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_win_q   <= WIN_A;
            starve_cnt_q <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            addr_hold_q  <= '0;
        end else begin
            last_win_q   <= last_win_d;
            starve_cnt_q <= starve_cnt_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            addr_hold_q  <= addr_hold_d;
        end
    end

    // RAM output is already aligned to the cycle after the grant.
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = mem_q;
    assign b_rdata  = mem_q;

endmodule
